// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, control states, single-cycle result mux.
// Latency: none (types and pure functions only).
// Backpressure: none.
package ula_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;

    // Widest datapath the result mux supports; callers zero-extend and truncate.
    localparam int ALU_MAX_W = 64;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    // True for the single-cycle opcodes that update res.
    function automatic logic writes_res(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || ((op >= OP_AND) && (op <= OP_SHL));
    endfunction

    // Single-cycle result; operands are zero-extended so truncation to W stays correct.
    function automatic logic [ALU_MAX_W-1:0] alu_result(input logic [3:0] op,
                                                        input logic [ALU_MAX_W-1:0] a,
                                                        input logic [ALU_MAX_W-1:0] b);
        logic [ALU_MAX_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~b;
            OP_SHR: r = b >> 1;
            OP_SHL: r = b << 1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ula_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one 2W working register.
// Latency: W cycles after go; fin and the final hi/lo are presented combinationally in the last one.
// Backpressure: none; go is only raised by the owner when idle, reset aborts a running operation.
module ula_muldiv #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         fin
);

    // MUL: p = {partial product, remaining multiplier bits}
    // DIV: p = {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*W-1:0] p;
    logic [2*W-1:0] p_nxt;
    logic [W-1:0]   opnd;
    logic           mode_div;
    logic           active;
    logic [CNT_W-1:0] cnt;

    logic [W:0]   sum;
    logic [W:0]   top;
    logic [W+1:0] diff;

    assign fin = active && (cnt == CNT_W'(W - 1));

    // One iteration step for either operation, plus result mapping from the stepped value.
    always_comb begin
        sum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        top   = p[2*W-1:W-1];
        diff  = {1'b0, top} - {2'b00, opnd};
        p_nxt = {sum, p[W-1:1]};
        if (mode_div) begin
            if (diff[W+1]) begin
                p_nxt = {top[W-1:0], p[W-2:0], 1'b0};
            end else begin
                p_nxt = {diff[W-1:0], p[W-2:0], 1'b1};
            end
        end
        hi = mode_div ? p_nxt[W-1:0]   : p_nxt[2*W-1:W];
        lo = mode_div ? p_nxt[2*W-1:W] : p_nxt[W-1:0];
    end

    // Load operands on go, then iterate W times.
    always_ff @(posedge clk) begin
        if (rst) begin
            p        <= '0;
            opnd     <= '0;
            mode_div <= 1'b0;
            active   <= 1'b0;
            cnt      <= '0;
        end else if (go) begin
            p        <= {{W{1'b0}}, (is_div ? a : b)};
            opnd     <= is_div ? b : a;
            mode_div <= is_div;
            active   <= 1'b1;
            cnt      <= '0;
        end else if (active) begin
            p   <= p_nxt;
            cnt <= cnt + 1'b1;
            if (fin) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Execute-stage ALU: single-cycle ops with registered result, plus iterative MUL/DIV into HI/LO.
// Latency: 1 edge for single-cycle ops and DIV by zero; W+1 edges to done for MUL/DIV.
// Backpressure: busy=1 while iterating; start is dropped while busy and in the FIN cycle.
module ula_mc import ula_pkg::*; #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   alu_op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    state_t       state;
    logic         go;
    logic         eng_fin;
    logic [W-1:0] eng_hi;
    logic [W-1:0] eng_lo;

    // Hand the operands to the engine only when an iterative op really starts.
    assign go = (state == IDLE) && start &&
                ((alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b != '0)));

    ula_muldiv #(.W(W), .CNT_W(CNT_W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .is_div (alu_op == OP_DIV),
        .a      (a),
        .b      (b),
        .hi     (eng_hi),
        .lo     (eng_lo),
        .fin    (eng_fin)
    );

    // Control FSM and all architectural output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            res      <= '0;
            zero     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alu_op == OP_MUL) begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end else if (alu_op == OP_DIV) begin
                            if (b == '0) begin
                                // Divide by zero resolves immediately, no iterations.
                                hi       <= '1;
                                lo       <= a;
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                            end else begin
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                        end else begin
                            done <= 1'b1;
                            if (alu_op == OP_CMP) begin
                                zero <= (a == b);
                            end
                            if (writes_res(alu_op)) begin
                                res <= W'(alu_result(alu_op, ALU_MAX_W'(a), ALU_MAX_W'(b)));
                            end
                        end
                    end
                end
                MUL, DIV: begin
                    if (eng_fin) begin
                        hi    <= eng_hi;
                        lo    <= eng_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                        if (state == DIV) begin
                            div_zero <= 1'b0;
                        end
                    end
                end
                // done is visible here with busy low; start is not sampled in this cycle.
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mc.sv
module tb_ula_mc;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] a, b;
    logic [W-1:0] res, hi, lo;
    logic         zero, busy, done, div_zero;

    logic          start8;
    logic [3:0]    alu_op8;
    logic [W8-1:0] a8, b8;
    logic [W8-1:0] res8, hi8, lo8;
    logic          zero8, busy8, done8, div_zero8;

    ula_mc #(.W(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
        .res(res), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_zero(div_zero)
    );

    ula_mc #(.W(W8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .alu_op(alu_op8), .a(a8), .b(b8),
        .res(res8), .zero(zero8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8),
        .div_zero(div_zero8)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    vec_t tbl[13];

    // Reference state of the architectural registers.
    logic [W-1:0] m_res, m_hi, m_lo;
    logic         m_zero, m_dz;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later; done must never coincide with busy.
    task automatic step();
        @(posedge clk);
        #1;
        n_cmp++;
        if ((done === 1'b1 && busy === 1'b1) || (done8 === 1'b1 && busy8 === 1'b1)) begin
            n_err++;
            $display("FAIL done_with_busy: done=%b busy=%b done8=%b busy8=%b", done, busy, done8, busy8);
        end
    endtask

    // Steps until done, bounded; returns the number of edges after the start edge.
    task automatic wait_done(input logic scramble, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (scramble) begin
                a      = $urandom;
                b      = $urandom;
                alu_op = 4'($urandom_range(0, 15));
            end
            step();
            lat++;
        end
        if (lat >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: timeout after %0d cycles", lat);
        end
    endtask

    // Architectural effect of one operation, from the opcode definitions.
    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int exp_lat);
        logic [2*W-1:0] prod;
        exp_lat = 0;
        case (op)
            4'd0:  m_res = x + y;
            4'd1:  m_res = x - y;
            4'd2: begin
                prod    = 64'(x) * 64'(y);
                m_hi    = prod[2*W-1:W];
                m_lo    = prod[W-1:0];
                exp_lat = W;
            end
            4'd3: begin
                if (y == 0) begin
                    m_hi = 32'hFFFF_FFFF;
                    m_lo = x;
                    m_dz = 1'b1;
                end else begin
                    m_hi    = x / y;
                    m_lo    = x % y;
                    m_dz    = 1'b0;
                    exp_lat = W;
                end
            end
            4'd4:  m_res = x & y;
            4'd5:  m_res = x | y;
            4'd6:  m_res = x ^ y;
            4'd7:  m_res = ~y;
            4'd8:  m_res = y / 2;
            4'd9:  m_res = y * 2;
            4'd10: m_zero = (x == y);
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "_res"}, res, m_res);
        check_bit({tag, "_zero"}, zero, m_zero);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
        check_bit({tag, "_dz"}, div_zero, m_dz);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        int exp_lat;
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;

        tbl[0]  = '{4'b0000, 32'd7,         32'd5,         32'd12,        1'b0};
        tbl[1]  = '{4'b0001, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        tbl[2]  = '{4'b1010, 32'd9,         32'd9,         32'hFFFF_FFFE, 1'b1};
        tbl[3]  = '{4'b0111, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
        tbl[4]  = '{4'b0100, 32'hF0,        32'h3C,        32'h30,        1'b1};
        tbl[5]  = '{4'b0101, 32'hF0,        32'h3C,        32'hFC,        1'b1};
        tbl[6]  = '{4'b0110, 32'hF0,        32'h3C,        32'hCC,        1'b1};
        tbl[7]  = '{4'b1000, 32'h5,         32'h8000_0001, 32'h4000_0000, 1'b1};
        tbl[8]  = '{4'b1001, 32'h5,         32'h8000_0001, 32'h0000_0002, 1'b1};
        tbl[9]  = '{4'b1010, 32'd1,         32'd2,         32'h0000_0002, 1'b0};
        tbl[10] = '{4'b1011, 32'd1,         32'd1,         32'h0000_0002, 1'b0};
        tbl[11] = '{4'b1111, 32'd3,         32'd3,         32'h0000_0002, 1'b0};
        tbl[12] = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0};

        rst = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
        start8 = 1'b0; alu_op8 = '0; a8 = '0; b8 = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_res", res, 0);
        check_bit("rst_zero", zero, 1'b0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_dz", div_zero, 1'b0);
        check("rst8_hi", 32'(hi8), 0);

        // Back-to-back single-cycle ops, one result per cycle
        for (int i = 0; i < 13; i++) begin
            start  = 1'b1;
            alu_op = tbl[i].op;
            a      = tbl[i].a;
            b      = tbl[i].b;
            step();
            check($sformatf("tbl%0d_res", i), res, tbl[i].exp_res);
            check_bit($sformatf("tbl%0d_zero", i), zero, tbl[i].exp_zero);
            check_bit($sformatf("tbl%0d_done", i), done, 1'b1);
            check_bit($sformatf("tbl%0d_busy", i), busy, 1'b0);
        end
        start = 1'b0;
        step();
        check_bit("idle_done", done, 1'b0);
        check("tbl_hi_held", hi, 0);
        check("tbl_lo_held", lo, 0);

        // MUL with a start held during busy, which must be ignored
        start = 1'b1; alu_op = 4'b0010; a = 32'hFFFF_FFFF; b = 32'd2;
        step();
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        check_bit("mul_start_done", done, 1'b0);
        alu_op = 4'b0000; a = 32'd1; b = 32'd1;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            step();
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (lat == 4) start = 1'b0;
        end
        check("mul_latency", lat, W);
        check("mul_busy_cycles", busy_cnt, W);
        check("mul_hi", hi, 32'd1);
        check("mul_lo", lo, 32'hFFFF_FFFE);
        check("mul_res_held", res, 32'h0);
        // start during FIN is dropped
        start = 1'b1; alu_op = 4'b0000; a = 32'd1; b = 32'd1;
        step();
        start = 1'b0;
        check_bit("fin_start_done", done, 1'b0);
        check("fin_start_res", res, 32'h0);
        step();

        // DIV 100/7
        start = 1'b1; alu_op = 4'b0011; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        wait_done(1'b1, lat);
        check("div_latency", lat, W);
        check("div_hi", hi, 32'd14);
        check("div_lo", lo, 32'd2);
        check_bit("div_dz", div_zero, 1'b0);
        step();

        // DIV by zero resolves at the start edge
        start = 1'b1; alu_op = 4'b0011; a = 32'd5; b = 32'd0;
        step();
        start = 1'b0;
        check_bit("dz_done", done, 1'b1);
        check_bit("dz_busy", busy, 1'b0);
        check("dz_hi", hi, 32'hFFFF_FFFF);
        check("dz_lo", lo, 32'd5);
        check_bit("dz_flag", div_zero, 1'b1);

        // div_zero is sticky across MUL
        start = 1'b1; alu_op = 4'b0010; a = 32'd3; b = 32'd5;
        step();
        start = 1'b0;
        wait_done(1'b0, lat);
        check("mul2_lo", lo, 32'd15);
        check("mul2_hi", hi, 32'd0);
        check_bit("mul2_dz_held", div_zero, 1'b1);
        step();

        // Reset in the middle of a MUL
        start = 1'b1; alu_op = 4'b0010; a = 32'd7; b = 32'd9;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_res", res, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_bit("abort_dz", div_zero, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_hi_stays", hi, 0);
        start = 1'b1; alu_op = 4'b0100; a = 32'hF0; b = 32'h3C;
        step();
        start = 1'b0;
        check("after_abort_and", res, 32'h30);
        check_bit("after_abort_done", done, 1'b1);

        // W=8 instance: MUL 0xFF*0xFF and a DIV
        start8 = 1'b1; alu_op8 = 4'b0010; a8 = 8'hFF; b8 = 8'hFF;
        step();
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check("w8_mul_latency", lat, W8);
        check("w8_mul_hi", 32'(hi8), 32'hFE);
        check("w8_mul_lo", 32'(lo8), 32'h01);
        step();
        start8 = 1'b1; alu_op8 = 4'b0011; a8 = 8'd200; b8 = 8'd7;
        step();
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check("w8_div_latency", lat, W8);
        check("w8_div_hi", 32'(hi8), 32'd28);
        check("w8_div_lo", 32'(lo8), 32'd4);
        check_bit("w8_div_dz", div_zero8, 1'b0);
        step();

        // Randomized operations against the reference model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_res = '0; m_hi = '0; m_lo = '0; m_zero = 1'b0; m_dz = 1'b0;
        check_model("rnd_reset");
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            if (i % 10 == 0) begin
                rop = 4'b0011;
                rb  = '0;
            end else if (i % 10 == 5) begin
                rop = 4'b0011;
            end else if (i % 10 == 7) begin
                rop = 4'b0010;
            end else if (i % 10 == 3) begin
                rop = 4'b1010;
                rb  = ra;
            end
            model_apply(rop, ra, rb, exp_lat);
            start = 1'b1; alu_op = rop; a = ra; b = rb;
            step();
            start = 1'b0;
            wait_done(1'b1, lat);
            check($sformatf("rnd%0d_latency", i), lat, exp_lat);
            check_model($sformatf("rnd%0d", i));
            if (exp_lat > 0) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
